counter: RTL and testbench

COUNTER -- requirements
Module: counter

---
 rtl/counter_if.sv | 30 +++
 rtl/counter.sv | 59 +++++
 tb/tb_counter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/counter_if.sv
// Counter control/status bundle: the master drives en/dn/load/data, the slave
// returns count and the combinational terminal-count flag tc.
interface counter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             en;
    logic             dn;
    logic             load;
    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] count;
    logic             tc;

    modport master (
        output en,
        output dn,
        output load,
        output data,
        input  count,
        input  tc
    );

    modport slave (
        input  en,
        input  dn,
        input  load,
        input  data,
        output count,
        output tc
    );
endinterface

// File: rtl/counter.sv
// Up/down counter with synchronous parallel load and async active-high reset.
// Define COUNTER_SAT_EN to saturate at the range ends instead of wrapping.
module counter #(
    parameter int unsigned WIDTH = 4
) (
    input logic       clk,
    input logic       rst,
    counter_if.slave  bus
);
    localparam logic [WIDTH-1:0] CntMax = '1;
    localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_max;
    logic             at_min;

    assign at_max = (count_q == CntMax);
    assign at_min = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (bus.load) begin
            count_d = bus.data;
        end else if (bus.en) begin
            if (bus.dn) begin
`ifdef COUNTER_SAT_EN
                count_d = at_min ? count_q : count_q - CntOne;
`else
                count_d = count_q - CntOne;
`endif
            end else begin
`ifdef COUNTER_SAT_EN
                count_d = at_max ? count_q : count_q + CntOne;
`else
                count_d = count_q + CntOne;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // rst gates tc explicitly: count is 0 in reset, which would otherwise flag a down-count.
    always_comb begin
        bus.tc = 1'b0;
        if (!rst && bus.en && !bus.load) begin
            bus.tc = bus.dn ? at_min : at_max;
        end
    end

    assign bus.count = count_q;
endmodule

// File: tb/tb_counter.sv
// Self-checking bench for counter: directed scenarios with literal expectations
// plus randomized stimulus against an arithmetic reference model.
module tb_counter;
    localparam int unsigned WIDTH = 4;
    localparam int Mod = 1 << WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   model = 0;

    counter_if #(.WIDTH(WIDTH)) bus ();

    counter #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic int next_val(int m, logic dn);
`ifdef COUNTER_SAT_EN
        if (dn) return (m == 0) ? 0 : m - 1;
        return (m == Mod - 1) ? m : m + 1;
`else
        if (dn) return (m + Mod - 1) % Mod;
        return (m + 1) % Mod;
`endif
    endfunction

    function automatic logic model_tc();
        if (rst || !bus.en || bus.load) return 1'b0;
        return bus.dn ? (model == 0) : (model == Mod - 1);
    endfunction

    task automatic drive(logic en, logic dn, logic load, int data);
        bus.en   = en;
        bus.dn   = dn;
        bus.load = load;
        bus.data = WIDTH'(data);
        #1;
    endtask

    // One rising edge; the model advances from the inputs sampled at that edge.
    task automatic tick();
        @(posedge clk);
        if (rst) model = 0;
        else if (bus.load) model = int'(bus.data);
        else if (bus.en) model = next_val(model, bus.dn);
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b0, 1'b0, 7);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.count !== 4'd0) $display("FAIL reset_async count=%0d want 0", bus.count);
        else n_pass++;
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 7);
        n_checks++;
        if (bus.tc !== 1'b0) $display("FAIL reset_tc tc=%0b want 0", bus.tc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.count !== 4'd0) $display("FAIL reset_hold count=%0d want 0", bus.count);
        else n_pass++;
        rst = 1'b0;
        model = 0;
        drive(1'b0, 1'b0, 1'b0, 7);
        tick();
        n_checks++;
        if (bus.count !== 4'd0) $display("FAIL reset_release count=%0d want 0", bus.count);
        else n_pass++;
    endtask

    task automatic test_up_load();
        int   exp_c[7] = '{1, 2, 3, 4, 7, 8, 9};
        logic ld[7]    = '{0, 0, 0, 0, 1, 0, 0};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 1'b0, ld[i], 7);
            tick();
            n_checks++;
            if (bus.count !== WIDTH'(exp_c[i]))
                $display("FAIL up_load[%0d] count=%0d want %0d", i, bus.count, exp_c[i]);
            else n_pass++;
        end
    endtask

    task automatic test_direction();
        int   exp_c[3] = '{8, 7, 8};
        logic dir[3]   = '{1, 1, 0};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, dir[i], 1'b0, 7);
            tick();
            n_checks++;
            if (bus.count !== WIDTH'(exp_c[i]))
                $display("FAIL direction[%0d] count=%0d want %0d", i, bus.count, exp_c[i]);
            else n_pass++;
        end
    endtask

    task automatic test_hold_load();
        int   exp_c[6] = '{7, 7, 7, 8, 9, 10};
        logic en_s[6]  = '{0, 0, 0, 1, 1, 1};
        logic dn_s[6]  = '{1, 1, 0, 0, 0, 0};
        logic ld_s[6]  = '{1, 0, 0, 0, 0, 0};
        for (int i = 0; i < 6; i++) begin
            drive(en_s[i], dn_s[i], ld_s[i], 7);
            tick();
            n_checks++;
            if (bus.count !== WIDTH'(exp_c[i]))
                $display("FAIL hold_load[%0d] count=%0d want %0d", i, bus.count, exp_c[i]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
`ifdef COUNTER_SAT_EN
        int up_exp = 15;
        int dn_exp = 0;
`else
        int up_exp = 0;
        int dn_exp = 15;
`endif
        drive(1'b1, 1'b0, 1'b1, 15);
        n_checks++;
        if (bus.tc !== 1'b0) $display("FAIL wrap_tc_load tc=%0b want 0", bus.tc);
        else n_pass++;
        tick();
        drive(1'b1, 1'b0, 1'b0, 0);
        n_checks++;
        if (bus.tc !== 1'b1) $display("FAIL wrap_tc_up tc=%0b want 1", bus.tc);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.count !== WIDTH'(up_exp))
            $display("FAIL wrap_up count=%0d want %0d", bus.count, up_exp);
        else n_pass++;
        drive(1'b1, 1'b1, 1'b1, 0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 0);
        n_checks++;
        if (bus.tc !== 1'b1) $display("FAIL wrap_tc_dn tc=%0b want 1", bus.tc);
        else n_pass++;
        tick();
        n_checks++;
        if (bus.count !== WIDTH'(dn_exp))
            $display("FAIL wrap_dn count=%0d want %0d", bus.count, dn_exp);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 1'b0, 1'b1, 9);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if (bus.count !== 4'd0) $display("FAIL midrst_async count=%0d want 0", bus.count);
        else n_pass++;
        n_checks++;
        if (bus.tc !== 1'b0) $display("FAIL midrst_tc tc=%0b want 0", bus.tc);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (bus.count !== 4'd0) $display("FAIL midrst_load count=%0d want 0", bus.count);
        else n_pass++;
        rst = 1'b0;
        model = 0;
        drive(1'b0, 1'b0, 1'b0, 9);
        tick();
        n_checks++;
        if (bus.count !== 4'd0) $display("FAIL midrst_release count=%0d want 0", bus.count);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 200; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, Mod - 1)));
            n_checks++;
            if (bus.tc !== model_tc())
                $display("FAIL random_tc[%0d] tc=%0b want %0b", i, bus.tc, model_tc());
            else n_pass++;
            tick();
            n_checks++;
            if (bus.count !== WIDTH'(model))
                $display("FAIL random_count[%0d] count=%0d want %0d", i, bus.count, model);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_up_load();
        test_direction();
        test_hold_load();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
